mac_pipe_op: RTL and testbench
==============================

# mac_pipe_op

Pipelined, flow-controlled multiply-accumulate unit for the integer-multiplier layer of the modular-multiplier datapath. It computes A*B and either passes the product through, adds E, subtracts E, or folds a multi-beat accumulation group into one result. Compared with the fixed-mode MAC it replaces, it has per-beat operation select, a valid/ready handshake with backpressure, a pass-through tag, and an internal accumulator. Montgomery/Barrett reduction front-ends drive it with product and correction terms.

## Interface
- LOGA, 64, width of unsigned operand A
- LOGB, 64, width of unsigned operand B
- LOGE, 128, width of unsigned addend/subtrahend E
- ACC_GUARD, 4, extra guard bits for accumulation groups
- MUL_STAGES, 2, register stages inside the multiplier (≥1)
- TAG_W, 8, width of the user tag carried alongside each beat
- LOGC (derived, not overridable), max(LOGA+LOGB, LOGE)+ACC_GUARD+1, two's-complement result width
- clk  in  1  clock. Single clock domain.
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_op  in  2  0 MUL, 1 ADD, 2 SUB, 3 ACC
- in_last  in  1  closes an ACC group; ignored for other ops
- in_tag  in  TAG_W  returned unchanged with the result
- A  in  LOGA  multiplicand
- B  in  LOGB  multiplier
- E  in  LOGE  addend/subtrahend; for ACC, initial value of the group
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- C  out  LOGC  result, two's complement
- out_tag  out  TAG_W  tag of the result beat

## Operation
- Operands are zero-extended to LOGC. All arithmetic wraps modulo 2^LOGC.
- MUL: C = A*B.
- ADD: C = A*B + E.
- SUB: C = A*B − E. A negative result appears with the MSB set.
- ACC: two-state FSM in the add stage.
  - ACC_IDLE: the first ACC beat sets S = E + A*B. If in_last=0, the FSM moves to ACC_RUN and no output is produced. If in_last=1, C = S, S is cleared, and the FSM stays in ACC_IDLE.
  - ACC_RUN: E is ignored and S = S + A*B. If in_last=0, no output is produced. If in_last=1, C = S_new, S is cleared, and the FSM goes to ACC_IDLE.
- Non-ACC beats may be interleaved inside an open ACC group. They produce their own result and leave S and the FSM untouched.
- out_tag of an ACC result is the tag of the in_last beat.
- Results leave in acceptance order. Absorbed (non-last) ACC beats emit nothing.

## Timing
- Global advance: adv = !out_valid || out_ready. in_ready = adv.
- Every pipeline register, including valid bits, loads only when adv=1.
- Latency with no stall: MUL_STAGES+2 cycles from input acceptance to out_valid. That is MUL_STAGES multiplier stages, 1 add/accumulate stage, and 1 output register.
- Throughput: one beat per cycle while out_ready=1.
- With out_valid=1 and out_ready=0:
  - C and out_tag hold stable.
  - in_ready=0 and no beat is accepted.
  - S and the FSM state are frozen.
- Bubbles (in_valid=0) propagate as invalid slots. They never alter S.
- Reset: all valid bits 0, out_valid=0, C=0, out_tag=0, S=0, FSM=ACC_IDLE, in_ready=1 from the first cycle after reset deasserts.
- Reset asserted mid-operation discards all in-flight beats and any open ACC group, with no partial output.
- Data registers other than S, C and out_tag have no reset requirement.

## Structure
- Package mac_pkg holds:
  - the op encoding enum (OP_MUL, OP_ADD, OP_SUB, OP_ACC)
  - the ACC FSM state enum
  - a constant function computing LOGC from LOGA, LOGB, LOGE and ACC_GUARD
- Sub-module mac_mul_pipe: the unsigned LOGA×LOGB multiplier with MUL_STAGES enable-gated registers. It carries valid, op, last, tag and E alongside the product.
- The top level contains the add/accumulate stage, the FSM, the output register and the handshake.

## Test plan
- MUL/ADD/SUB with A=3, B=5, E=7, out_ready=1, one beat each:
  - C = 15, 22, 8 respectively.
  - Each result arrives exactly MUL_STAGES+2 cycles after acceptance.
  - Tags return intact.
- SUB underflow with A=2^64−1, B=8963783824838420066, E=2^128−1: C = (A*B − E) mod 2^LOGC, MSB of C = 1.
- ACC group (2,3,E=10), (4,5), (1,1,last), tags 1,2,3: exactly one result, C=37, out_tag=3. FSM returns to ACC_IDLE and the next ACC starts from its own E.
- Interleave: ACC (2,3,E=0) followed by MUL (3,5) and then ACC (4,5,last). Expected output order is 15 then 26.
- Backpressure:
  - Stream 10 ADD beats with out_ready toggling randomly.
  - No results are lost or duplicated and all arrive in order.
  - C holds stable while stalled.
  - in_ready tracks adv every cycle.
- Reset mid-operation:
  - Assert rst with 3 beats in flight and an open ACC group.
  - out_valid=0 the cycle after rst.
  - A new ACC (1,1,E=0,last) then yields C=1.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and width helpers for the pipelined multiply-accumulate unit.
package mac_pkg;

    // Per-beat operation select.
    typedef enum logic [1:0] {
        OP_MUL = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2,
        OP_ACC = 2'd3
    } op_e;

    // Accumulation-group state: idle waits for a group opener, run adds onto S.
    typedef enum logic {
        ACC_IDLE = 1'b0,
        ACC_RUN  = 1'b1
    } acc_st_e;

    // Result width: widest of product and addend, plus guard bits, plus a sign bit.
    function automatic int unsigned calc_logc(input int unsigned loga, input int unsigned logb,
                                              input int unsigned loge, input int unsigned guard);
        int unsigned w;
        w = (loga + logb > loge) ? (loga + logb) : loge;
        return w + guard + 1;
    endfunction

endpackage

// File: rtl/mac_mul_pipe.sv
// Unsigned LOGA x LOGB multiplier with MUL_STAGES enable-gated register stages.
// Beat sideband (valid, op, last, tag, E) travels in lockstep with the product.
module mac_mul_pipe
    import mac_pkg::*;
#(
    parameter int unsigned LOGA       = 64,
    parameter int unsigned LOGB       = 64,
    parameter int unsigned LOGE       = 128,
    parameter int unsigned MUL_STAGES = 2,
    parameter int unsigned TAG_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_i,
    input  logic                   valid_i,
    input  op_e                    op_i,
    input  logic                   last_i,
    input  logic [TAG_W-1:0]       tag_i,
    input  logic [LOGA-1:0]        a_i,
    input  logic [LOGB-1:0]        b_i,
    input  logic [LOGE-1:0]        e_i,
    output logic                   valid_o,
    output op_e                    op_o,
    output logic                   last_o,
    output logic [TAG_W-1:0]       tag_o,
    output logic [LOGA+LOGB-1:0]   prod_o,
    output logic [LOGE-1:0]        e_o
);

    localparam int unsigned PW = LOGA + LOGB;

    // Product is formed ahead of the first stage; the trailing registers let
    // synthesis retime the multiplier array across MUL_STAGES.
    logic [PW-1:0] prod_c;
    assign prod_c = PW'(a_i) * PW'(b_i);

    logic [MUL_STAGES-1:0] vld_q;
    logic [PW-1:0]         prod_q [MUL_STAGES];
    op_e                   op_q   [MUL_STAGES];
    logic                  last_q [MUL_STAGES];
    logic [TAG_W-1:0]      tag_q  [MUL_STAGES];
    logic [LOGE-1:0]       e_q    [MUL_STAGES];

    // Valid chain: cleared by reset so in-flight beats are discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else if (en_i) begin
            vld_q[0] <= valid_i;
            for (int i = 1; i < MUL_STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Data chain: no reset needed, qualified by the valid chain.
    always_ff @(posedge clk) begin
        if (en_i) begin
            prod_q[0] <= prod_c;
            op_q[0]   <= op_i;
            last_q[0] <= last_i;
            tag_q[0]  <= tag_i;
            e_q[0]    <= e_i;
            for (int i = 1; i < MUL_STAGES; i++) begin
                prod_q[i] <= prod_q[i-1];
                op_q[i]   <= op_q[i-1];
                last_q[i] <= last_q[i-1];
                tag_q[i]  <= tag_q[i-1];
                e_q[i]    <= e_q[i-1];
            end
        end
    end

    assign valid_o = vld_q[MUL_STAGES-1];
    assign op_o    = op_q[MUL_STAGES-1];
    assign last_o  = last_q[MUL_STAGES-1];
    assign tag_o   = tag_q[MUL_STAGES-1];
    assign prod_o  = prod_q[MUL_STAGES-1];
    assign e_o     = e_q[MUL_STAGES-1];

endmodule

// File: rtl/mac_pipe_op.sv
// Flow-controlled multiply-accumulate: multiplier pipe, add/accumulate stage,
// output register. A single advance signal gates every stage so a stalled
// output freezes the whole pipe, including the accumulator and its FSM.
module mac_pipe_op
    import mac_pkg::*;
#(
    parameter int unsigned LOGA       = 64,
    parameter int unsigned LOGB       = 64,
    parameter int unsigned LOGE       = 128,
    parameter int unsigned ACC_GUARD  = 4,
    parameter int unsigned MUL_STAGES = 2,
    parameter int unsigned TAG_W      = 8,
    localparam int unsigned LOGC      = calc_logc(LOGA, LOGB, LOGE, ACC_GUARD)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic               in_last,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic [LOGA-1:0]    A,
    input  logic [LOGB-1:0]    B,
    input  logic [LOGE-1:0]    E,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LOGC-1:0]    C,
    output logic [TAG_W-1:0]   out_tag
);

    logic adv;

    logic                 m_valid;
    op_e                  m_op;
    logic                 m_last;
    logic [TAG_W-1:0]     m_tag;
    logic [LOGA+LOGB-1:0] m_prod;
    logic [LOGE-1:0]      m_e;

    logic [LOGC-1:0]  s_q, s_d;
    acc_st_e          st_q, st_d;
    logic [LOGC-1:0]  res_d;
    logic             emit_d;

    logic             add_vld_q;
    logic [LOGC-1:0]  add_res_q;
    logic [TAG_W-1:0] add_tag_q;

    logic             out_vld_q;
    logic [LOGC-1:0]  c_q;
    logic [TAG_W-1:0] tag_q;

    assign adv      = !out_vld_q || out_ready;
    assign in_ready = adv;

    mac_mul_pipe #(
        .LOGA       (LOGA),
        .LOGB       (LOGB),
        .LOGE       (LOGE),
        .MUL_STAGES (MUL_STAGES),
        .TAG_W      (TAG_W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .en_i    (adv),
        .valid_i (in_valid),
        .op_i    (op_e'(in_op)),
        .last_i  (in_last),
        .tag_i   (in_tag),
        .a_i     (A),
        .b_i     (B),
        .e_i     (E),
        .valid_o (m_valid),
        .op_o    (m_op),
        .last_o  (m_last),
        .tag_o   (m_tag),
        .prod_o  (m_prod),
        .e_o     (m_e)
    );

    // Add/accumulate datapath and ACC FSM next-state; bubbles leave S untouched.
    always_comb begin
        logic [LOGC-1:0] prod_x;
        logic [LOGC-1:0] e_x;
        logic [LOGC-1:0] acc_sum;
        prod_x  = LOGC'(m_prod);
        e_x     = LOGC'(m_e);
        acc_sum = ((st_q == ACC_IDLE) ? e_x : s_q) + prod_x;
        res_d   = prod_x;
        emit_d  = m_valid;
        s_d     = s_q;
        st_d    = st_q;
        case (m_op)
            OP_MUL: res_d = prod_x;
            OP_ADD: res_d = prod_x + e_x;
            OP_SUB: res_d = prod_x - e_x;
            OP_ACC: begin
                res_d = acc_sum;
                if (m_valid) begin
                    if (m_last) begin
                        s_d  = '0;
                        st_d = ACC_IDLE;
                    end else begin
                        // Absorbed beat: fold into S, emit nothing.
                        s_d    = acc_sum;
                        st_d   = ACC_RUN;
                        emit_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Accumulator and FSM state, frozen while the output is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q  <= '0;
            st_q <= ACC_IDLE;
        end else if (adv) begin
            s_q  <= s_d;
            st_q <= st_d;
        end
    end

    // Add-stage valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            add_vld_q <= 1'b0;
        end else if (adv) begin
            add_vld_q <= emit_d;
        end
    end

    // Add-stage data register.
    always_ff @(posedge clk) begin
        if (adv) begin
            add_res_q <= res_d;
            add_tag_q <= m_tag;
        end
    end

    // Output register; C and out_tag only change when a real result lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q <= 1'b0;
            c_q       <= '0;
            tag_q     <= '0;
        end else if (adv) begin
            out_vld_q <= add_vld_q;
            if (add_vld_q) begin
                c_q   <= add_res_q;
                tag_q <= add_tag_q;
            end
        end
    end

    assign out_valid = out_vld_q;
    assign C         = c_q;
    assign out_tag   = tag_q;

endmodule

// File: tb/tb_mac_pipe_op.sv
// Directed self-checking bench for mac_pipe_op with default parameters.
module tb_mac_pipe_op;

    localparam int LOGC = 133;
    localparam int LAT  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic              in_last;
    logic [7:0]        in_tag;
    logic [63:0]       A;
    logic [63:0]       B;
    logic [127:0]      E;
    logic              out_valid;
    logic              out_ready;
    logic [LOGC-1:0]   C;
    logic [7:0]        out_tag;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    bit rnd_mode = 1'b0;

    logic [LOGC-1:0] q_c[$];
    logic [7:0]      q_tag[$];
    int              q_cyc[$];

    bit              prev_stall = 1'b0;
    logic [LOGC-1:0] prev_c;
    logic [7:0]      prev_tag;

    mac_pipe_op dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_last   (in_last),
        .in_tag    (in_tag),
        .A         (A),
        .B         (B),
        .E         (E),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .C         (C),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [LOGC-1:0] obs,
                         input logic [LOGC-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Output monitor: handshake capture, stall stability, in_ready tracking.
    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready_adv", LOGC'(in_ready), LOGC'(!out_valid || out_ready));
            if (prev_stall) begin
                check("stall_valid", LOGC'(out_valid), LOGC'(1));
                check("stall_c", C, prev_c);
                check("stall_tag", LOGC'(out_tag), LOGC'(prev_tag));
            end
            if (out_valid && out_ready) begin
                q_c.push_back(C);
                q_tag.push_back(out_tag);
                q_cyc.push_back(cyc);
            end
            prev_stall = out_valid && !out_ready;
            prev_c     = C;
            prev_tag   = out_tag;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [127:0] e, input logic last, input logic [7:0] tag);
        bit done;
        done     = 1'b0;
        in_op    = op;
        A        = a;
        B        = b;
        E        = e;
        in_last  = last;
        in_tag   = tag;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                done    = 1'b1;
                acc_cyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("accept_bound", LOGC'(done), LOGC'(1));
    endtask

    task automatic get(output logic [LOGC-1:0] c, output logic [7:0] tag, output int oc);
        for (int k = 0; k < 200 && q_c.size() == 0; k++) begin
            @(posedge clk);
            #1;
        end
        check("result_bound", LOGC'(q_c.size() != 0), LOGC'(1));
        if (q_c.size() != 0) begin
            c   = q_c.pop_front();
            tag = q_tag.pop_front();
            oc  = q_cyc.pop_front();
        end else begin
            c   = '0;
            tag = '0;
            oc  = 0;
        end
    endtask

    task automatic expect_out(input string name, input logic [LOGC-1:0] exp_c,
                              input logic [7:0] exp_tag);
        logic [LOGC-1:0] c;
        logic [7:0]      t;
        int              oc;
        get(c, t, oc);
        check({name, "_c"}, c, exp_c);
        check({name, "_tag"}, LOGC'(t), LOGC'(exp_tag));
    endtask

    task automatic expect_lat(input string name, input logic [LOGC-1:0] exp_c,
                              input logic [7:0] exp_tag);
        logic [LOGC-1:0] c;
        logic [7:0]      t;
        int              oc;
        get(c, t, oc);
        check({name, "_c"}, c, exp_c);
        check({name, "_tag"}, LOGC'(t), LOGC'(exp_tag));
        check({name, "_lat"}, LOGC'(oc - acc_cyc), LOGC'(LAT));
    endtask

    initial begin
        logic [LOGC-1:0] exp_c;
        logic [LOGC-1:0] got_c;
        logic [7:0]      got_t;
        int              got_cyc;
        logic [63:0]     a_v;
        logic [63:0]     b_v;
        logic [127:0]    e_v;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_op    = 2'd0;
        in_last  = 1'b0;
        in_tag   = '0;
        A        = '0;
        B        = '0;
        E        = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_out_valid", LOGC'(out_valid), LOGC'(0));
        check("rst_c", C, LOGC'(0));
        check("rst_tag", LOGC'(out_tag), LOGC'(0));
        check("rst_in_ready", LOGC'(in_ready), LOGC'(1));
        @(posedge clk);
        #1;

        // Single MUL / ADD / SUB beats with latency.
        send(2'd0, 64'd3, 64'd5, 128'd7, 1'b0, 8'h11);
        expect_lat("mul", LOGC'(15), 8'h11);
        send(2'd1, 64'd3, 64'd5, 128'd7, 1'b0, 8'h12);
        expect_lat("add", LOGC'(22), 8'h12);
        send(2'd2, 64'd3, 64'd5, 128'd7, 1'b0, 8'h13);
        expect_lat("sub", LOGC'(8), 8'h13);

        // SUB underflow wraps with the sign bit set.
        a_v = {64{1'b1}};
        b_v = 64'd8963783824838420066;
        e_v = {128{1'b1}};
        exp_c = LOGC'(a_v) * LOGC'(b_v) - LOGC'(e_v);
        send(2'd2, a_v, b_v, e_v, 1'b0, 8'h14);
        get(got_c, got_t, got_cyc);
        check("subneg_c", got_c, exp_c);
        check("subneg_msb", LOGC'(got_c[LOGC-1]), LOGC'(1));
        check("subneg_tag", LOGC'(got_t), LOGC'(8'h14));

        // Three-beat ACC group: 10 + 6 + 20 + 1.
        send(2'd3, 64'd2, 64'd3, 128'd10, 1'b0, 8'd1);
        send(2'd3, 64'd4, 64'd5, 128'd999, 1'b0, 8'd2);
        send(2'd3, 64'd1, 64'd1, 128'd999, 1'b1, 8'd3);
        expect_out("acc3", LOGC'(37), 8'd3);
        repeat (10) @(posedge clk);
        #1;
        check("acc3_single", LOGC'(q_c.size()), LOGC'(0));
        // Next group starts from its own E.
        send(2'd3, 64'd1, 64'd2, 128'd5, 1'b1, 8'd4);
        expect_out("acc_fresh", LOGC'(7), 8'd4);

        // MUL interleaved inside an open ACC group.
        send(2'd3, 64'd2, 64'd3, 128'd0, 1'b0, 8'd5);
        send(2'd0, 64'd3, 64'd5, 128'd0, 1'b0, 8'd6);
        send(2'd3, 64'd4, 64'd5, 128'd0, 1'b1, 8'd7);
        expect_out("ilv_mul", LOGC'(15), 8'd6);
        expect_out("ilv_acc", LOGC'(26), 8'd7);

        // Back-to-back ADD stream under random backpressure.
        rnd_mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(2'd1, 64'(i + 3), 64'(i + 7), 128'(i * 1000 + 1), 1'b0, 8'(8'h40 + i));
        end
        for (int i = 0; i < 10; i++) begin
            exp_c = LOGC'((i + 3) * (i + 7) + i * 1000 + 1);
            expect_out($sformatf("bp%0d", i), exp_c, 8'(8'h40 + i));
        end
        rnd_mode = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("bp_no_dup", LOGC'(q_c.size()), LOGC'(0));

        // Reset with an open ACC group and three ADD beats in flight.
        send(2'd3, 64'd1, 64'd1, 128'd0, 1'b0, 8'h50);
        send(2'd1, 64'd1, 64'd1, 128'd1, 1'b0, 8'h51);
        send(2'd1, 64'd1, 64'd1, 128'd2, 1'b0, 8'h52);
        send(2'd1, 64'd1, 64'd1, 128'd3, 1'b0, 8'h53);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_out_valid", LOGC'(out_valid), LOGC'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("rst_mid_no_output", LOGC'(q_c.size()), LOGC'(0));
        send(2'd3, 64'd1, 64'd1, 128'd0, 1'b1, 8'h60);
        expect_out("post_rst_acc", LOGC'(1), 8'h60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
